// File: rtl/sb_pkg.sv
// sb_pkg: shared widths, entry type and port-select encoding for the store buffer
package sb_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_AW = 16;
  localparam int SB_DW = 16;
  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;
  typedef enum logic [1:0] {PS_IDLE, PS_LOAD, PS_DRAIN} port_sel_t;
endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: youngest-first address match over the queued entries
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  sb_entry_t [DEPTH-1:0]        entries,
  input  logic [$clog2(DEPTH)-1:0]     rd_ptr,
  input  logic [$clog2(DEPTH+1)-1:0]   count,
  input  logic [SB_AW-1:0]             addr,
  output logic                         hit,
  output logic [SB_DW-1:0]             data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  // walk oldest to youngest so the last match wins
  always_comb begin
    hit = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count && entries[rd_ptr + PW'(i)].addr == addr) begin
        hit = 1'b1;
        data = entries[rd_ptr + PW'(i)].data;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO in front of data_mem with load forwarding and fence drain
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW = SB_AW,
  parameter int DW = SB_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic [DW-1:0] ld_data,
  input  logic          fence,
  output logic          stall,
  output logic          empty,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  sb_entry_t [DEPTH-1:0] entries;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic full, queued, accept, fwd_hit;
  logic [DW-1:0] fwd_data;
  port_sel_t sel;
  sb_fwd_match #(.DEPTH(DEPTH)) u_match (
    .entries(entries),
    .rd_ptr(rd_ptr),
    .count(count),
    .addr(ld_addr),
    .hit(fwd_hit),
    .data(fwd_data)
  );
  assign full = count == CW'(DEPTH);
  assign queued = count != '0;
  assign empty = rst || !queued;
  // a fence drains regardless of a waiting store; otherwise a store blocks drain unless full
  always_comb begin
    sel = rst ? PS_IDLE : ld_valid ? PS_LOAD :
          (queued && (!st_valid || full || fence)) ? PS_DRAIN : PS_IDLE;
    accept = !rst && st_valid && !ld_valid && !full && !fence;
    stall = !rst && ((full && st_valid) || (fence && queued));
    mem_re = sel == PS_LOAD;
    mem_we = sel == PS_DRAIN;
    mem_addr = sel == PS_LOAD ? ld_addr : sel == PS_DRAIN ? entries[rd_ptr].addr : '0;
    mem_wdata = sel == PS_DRAIN ? entries[rd_ptr].data : '0;
    ld_data = sel == PS_LOAD ? (fwd_hit ? fwd_data : mem_rdata) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      err <= 1'b0;
    end else begin
      wr_ptr <= accept ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= mem_we ? rd_ptr + 1'b1 : rd_ptr;
      count <= accept ? count + 1'b1 : mem_we ? count - 1'b1 : count;
      err <= err || (st_valid && ld_valid);
    end
  end
  always_ff @(posedge clk) begin
    if (accept) entries[wr_ptr] <= '{addr: st_addr, data: st_data};
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenario checks for store_buffer
module tb_store_buffer;
  logic clk = 1'b0;
  logic rst, st_valid, ld_valid, fence;
  logic [15:0] st_addr, st_data, ld_addr, ld_data, mem_addr, mem_wdata, mem_rdata;
  logic stall, empty, err, mem_we, mem_re;
  int errors = 0;
  int checks = 0;

  store_buffer dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .fence(fence),
    .stall(stall), .empty(empty), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = ~mem_addr;

  task automatic drive(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                       input logic lv, input logic [15:0] la, input logic f);
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la; fence = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0007, 1'b0);
    checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL rst_re got=%0h exp=0", mem_re); end
    checks++; if (ld_data !== 16'h0) begin errors++; $display("FAIL rst_ld_data got=%0h exp=0", ld_data); end
    tick();
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%0h exp=1", empty); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0h exp=0", stall); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0h exp=0", err); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%0h exp=0", mem_we); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store_idle();
    drive(1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0, 1'b0);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL st_accept_we got=%0h exp=0", mem_we); end
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL st_queued_empty got=%0h exp=0", empty); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL st_drain_we got=%0h exp=1", mem_we); end
    checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL st_drain_addr got=%0h exp=0010", mem_addr); end
    checks++; if (mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL st_drain_data got=%0h exp=beef", mem_wdata); end
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL st_after_empty got=%0h exp=1", empty); end
  endtask

  task automatic test_forward();
    drive(1'b1, 16'h0005, 16'h1111, 1'b0, 16'h0, 1'b0);
    tick();
    drive(1'b1, 16'h0005, 16'h2222, 1'b0, 16'h0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0005, 1'b0);
    checks++; if (ld_data !== 16'h2222) begin errors++; $display("FAIL fwd_youngest got=%0h exp=2222", ld_data); end
    checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL fwd_re got=%0h exp=1", mem_re); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fwd_no_drain got=%0h exp=0", mem_we); end
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0006, 1'b0);
    checks++; if (ld_data !== 16'hFFF9) begin errors++; $display("FAIL fwd_miss got=%0h exp=fff9", ld_data); end
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    checks++; if (mem_wdata !== 16'h1111) begin errors++; $display("FAIL fwd_drain0 got=%0h exp=1111", mem_wdata); end
    tick();
    checks++; if (mem_wdata !== 16'h2222) begin errors++; $display("FAIL fwd_drain1 got=%0h exp=2222", mem_wdata); end
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fwd_empty got=%0h exp=1", empty); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h0020 + 16'(i), 16'h0100 + 16'(i), 1'b0, 16'h0, 1'b0);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_fill_stall i=%0d got=%0h exp=0", i, stall); end
      tick();
    end
    drive(1'b1, 16'h0024, 16'h0104, 1'b0, 16'h0, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall got=%0h exp=1", stall); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h0020) begin errors++; $display("FAIL full_drain we=%0h addr=%0h exp=1/0020", mem_we, mem_addr); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_stall_once got=%0h exp=0", stall); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL full_accept_we got=%0h exp=0", mem_we); end
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 16'h0020 + 16'(i) || mem_wdata !== 16'h0100 + 16'(i)) begin
        errors++; $display("FAIL full_order i=%0d we=%0h addr=%0h data=%0h", i, mem_we, mem_addr, mem_wdata);
      end
      tick();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty got=%0h exp=1", empty); end
  endtask

  task automatic test_fence();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0030 + 16'(i), 16'h0300 + 16'(i), 1'b0, 16'h0, 1'b0);
      tick();
    end
    drive(1'b1, 16'h0040, 16'h0400, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0030 + 16'(i) || mem_wdata !== 16'h0300 + 16'(i)) begin
        errors++; $display("FAIL fence_drain i=%0d stall=%0h we=%0h addr=%0h data=%0h", i, stall, mem_we, mem_addr, mem_wdata);
      end
      tick();
    end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fence_release got=%0h exp=0", stall); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fence_empty got=%0h exp=1", empty); end
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fence_no_accept got=%0h exp=1", empty); end
  endtask

  task automatic test_overlap_wrap();
    drive(1'b1, 16'h0050, 16'hDEAD, 1'b1, 16'h0050, 1'b0);
    checks++; if (mem_re !== 1'b1 || ld_data !== 16'hFFAF) begin errors++; $display("FAIL ovl_load re=%0h data=%0h exp=1/ffaf", mem_re, ld_data); end
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovl_err got=%0h exp=1", err); end
    checks++; if (empty !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL ovl_discard empty=%0h we=%0h exp=1/0", empty, mem_we); end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'h0060 + 16'(i), 16'h0600 + 16'(i), 1'b0, 16'h0, 1'b0);
      tick();
      drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 16'h0060 + 16'(i) || mem_wdata !== 16'h0600 + 16'(i)) begin
        errors++; $display("FAIL wrap_drain i=%0d we=%0h addr=%0h data=%0h", i, mem_we, mem_addr, mem_wdata);
      end
      tick();
    end
    checks++; if (empty !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL wrap_end empty=%0h err=%0h exp=1/1", empty, err); end
  endtask

  initial begin
    test_reset();
    test_store_idle();
    test_forward();
    test_full();
    test_fence();
    test_overlap_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
